// File: rtl/sha2cuctrl_pkg.sv
// sha2_pkg: shared state encoding and sizing constants for the SHA-2 compression control path
package sha2_pkg;
    localparam int SHA256_ROUNDS = 64;
    localparam int SCHED_WORDS = 16;
    typedef enum logic [2:0] {IDLE, INIT, LDWV, ROUND, UPD, DONE} state_e;
endpackage

// File: rtl/sha2cuctrl_if.sv
// sha2cuctrl_if: block handshake from the input unit plus datapath enables of the compression unit
interface sha2cuctrl_if #(
    parameter int RND_W = 6
);
    logic             blk_val;
    logic             msg_end;
    logic             blk_ack;
    logic             ld_blk;
    logic             init_hv;
    logic             ld_wv;
    logic             rnd_en;
    logic [RND_W-1:0] rnd;
    logic             w_exp;
    logic             upd_hv;
    logic             dgst_val;
    logic             busy;
    modport master (
        input  blk_val, msg_end,
        output blk_ack, ld_blk, init_hv, ld_wv, rnd_en, rnd, w_exp, upd_hv, dgst_val, busy
    );
    modport slave (
        output blk_val, msg_end,
        input  blk_ack, ld_blk, init_hv, ld_wv, rnd_en, rnd, w_exp, upd_hv, dgst_val, busy
    );
endinterface

// File: rtl/sha2cuctrl_rndcnt.sv
// sha2rndcnt: round index counter with clear, enable and a terminal flag at the last round
module sha2rndcnt #(
    parameter int ROUNDS = 64,
    parameter int RND_W = $clog2(ROUNDS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [RND_W-1:0] cnt_o,
    output logic             tc_o
);
    logic [RND_W-1:0] cnt_q, cnt_d;
    always_comb cnt_d = clr_i ? '0 : en_i ? cnt_q + RND_W'(1) : cnt_q;
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else cnt_q <= cnt_d;
    end
    assign cnt_o = cnt_q;
    assign tc_o = cnt_q == RND_W'(ROUNDS - 1);
endmodule

// File: rtl/sha2cuctrl.sv
// sha2cuctrl: per-block FSM sequencing load, H init/reuse, round loop and H update of the SHA-2 core
module sha2cuctrl #(
    parameter int ROUNDS = sha2_pkg::SHA256_ROUNDS,
    parameter int SCHED_WORDS = sha2_pkg::SCHED_WORDS,
    parameter int RND_W = $clog2(ROUNDS)
) (
    input logic          clk,
    input logic          rst,
    sha2cuctrl_if.master io
);
    import sha2_pkg::*;
    state_e           state_q, state_d;
    logic             first_q, first_d, lst_q, lst_d;
    logic             cnt_clr, cnt_en, cnt_tc;
    logic [RND_W-1:0] rnd_q;
    logic             blk_ack, ld_blk, init_hv, ld_wv, rnd_en, w_exp, upd_hv, dgst_val;
    sha2rndcnt #(.ROUNDS(ROUNDS), .RND_W(RND_W)) u_rndcnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (cnt_clr),
        .en_i  (cnt_en),
        .cnt_o (rnd_q),
        .tc_o  (cnt_tc)
    );
    // Outputs are forced low while rst is high so an abort is visible in the same cycle
    always_comb begin
        state_d  = state_q;
        first_d  = first_q;
        lst_d    = lst_q;
        cnt_clr  = 1'b0;
        cnt_en   = 1'b0;
        blk_ack  = 1'b0;
        ld_blk   = 1'b0;
        init_hv  = 1'b0;
        ld_wv    = 1'b0;
        rnd_en   = 1'b0;
        w_exp    = 1'b0;
        upd_hv   = 1'b0;
        dgst_val = 1'b0;
        if (!rst) begin
            unique case (state_q)
                IDLE: if (io.blk_val) begin
                    blk_ack = 1'b1;
                    ld_blk  = 1'b1;
                    lst_d   = io.msg_end;
                    state_d = first_q ? INIT : LDWV;
                end
                INIT: begin
                    init_hv = 1'b1;
                    state_d = LDWV;
                end
                LDWV: begin
                    ld_wv   = 1'b1;
                    cnt_clr = 1'b1;
                    state_d = ROUND;
                end
                ROUND: begin
                    rnd_en  = 1'b1;
                    w_exp   = int'(rnd_q) >= SCHED_WORDS;
                    cnt_clr = cnt_tc;
                    cnt_en  = !cnt_tc;
                    state_d = cnt_tc ? UPD : ROUND;
                end
                UPD: begin
                    upd_hv  = 1'b1;
                    first_d = lst_q;
                    state_d = lst_q ? DONE : IDLE;
                end
                DONE: begin
                    dgst_val = 1'b1;
                    state_d  = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            first_q <= 1'b1;
            lst_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            first_q <= first_d;
            lst_q   <= lst_d;
        end
    end
    assign io.blk_ack  = blk_ack;
    assign io.ld_blk   = ld_blk;
    assign io.init_hv  = init_hv;
    assign io.ld_wv    = ld_wv;
    assign io.rnd_en   = rnd_en;
    assign io.rnd      = rst ? '0 : rnd_q;
    assign io.w_exp    = w_exp;
    assign io.upd_hv   = upd_hv;
    assign io.dgst_val = dgst_val;
    assign io.busy     = !rst && state_q != IDLE;
endmodule

// File: tb/tb_sha2cuctrl.sv
// tb_sha2cuctrl: directed and random stimulus checked cycle by cycle against a block-offset timing model
module tb_sha2cuctrl;
    localparam int ROUNDS = 64;
    localparam int SW = 16;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   ack_q[$];
    int   dgst_q[$];
    int   init_n = 0;
    int   upd_n = 0;
    bit   m_act = 1'b0, m_f = 1'b0, m_l = 1'b0, m_first = 1'b1;
    int   m_o = 0;
    sha2cuctrl_if #(.RND_W(6)) bus ();
    sha2cuctrl dut (.clk(clk), .rst(rst), .io(bus));
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0d: got %0h want %0h", tag, cyc, got, exp);
        end
    endtask

    // Expected outputs follow from the offset since blk_ack; the round phase starts at 2 (+1 for INIT)
    task automatic step(input logic r, input logic v, input logic e);
        logic [8:0] ev, ov;
        int ph, rr;
        bit on;
        @(negedge clk);
        rst = r;
        bus.blk_val = v;
        bus.msg_end = e;
        #1;
        ev = '0;
        rr = 0;
        if (!r) begin
            if (!m_act) begin
                ev[8] = v;
                ev[7] = v;
            end else begin
                ph = 2 + int'(m_f);
                on = m_o >= ph && m_o < ph + ROUNDS;
                rr = on ? m_o - ph : 0;
                ev[6] = m_f && m_o == 1;
                ev[5] = m_o == ph - 1;
                ev[4] = on;
                ev[3] = on && rr >= SW;
                ev[2] = m_o == ph + ROUNDS;
                ev[1] = m_l && m_o == ph + ROUNDS + 1;
                ev[0] = 1'b1;
            end
        end
        ov = {bus.blk_ack, bus.ld_blk, bus.init_hv, bus.ld_wv, bus.rnd_en, bus.w_exp,
              bus.upd_hv, bus.dgst_val, bus.busy};
        check("outs", 32'(ov), 32'(ev));
        check("rnd", 32'(bus.rnd), 32'(rr));
        if (bus.blk_ack) ack_q.push_back(cyc);
        if (bus.dgst_val) dgst_q.push_back(cyc);
        if (bus.init_hv) init_n++;
        if (bus.upd_hv) upd_n++;
        if (r) begin
            m_act = 1'b0;
            m_first = 1'b1;
        end else if (!m_act) begin
            if (v) begin
                m_act = 1'b1;
                m_o = 1;
                m_f = m_first;
                m_l = e;
            end
        end else begin
            ph = 2 + int'(m_f);
            if (m_o == ph + ROUNDS) m_first = m_l;
            if (m_o == ph + ROUNDS + int'(m_l)) m_act = 1'b0;
            else m_o++;
        end
        cyc++;
    endtask

    task automatic clr_log();
        ack_q.delete();
        dgst_q.delete();
        init_n = 0;
        upd_n = 0;
        cyc = 0;
    endtask

    initial begin
        bit hit;
        bus.blk_val = 1'b0;
        bus.msg_end = 1'b0;
        // reset held with blk_val high
        repeat (3) step(1'b1, 1'b1, 1'b0);
        check("rst_noack", 32'(ack_q.size()), 32'd0);
        // single-block message
        clr_log();
        step(1'b0, 1'b1, 1'b1);
        repeat (74) step(1'b0, 1'b0, 1'b0);
        check("sb_acks", 32'(ack_q.size()), 32'd1);
        check("sb_ack0", 32'(ack_q.size() > 0 ? ack_q[0] : -1), 32'd0);
        check("sb_dgst", 32'(dgst_q.size() > 0 ? dgst_q[0] : -1), 32'd68);
        check("sb_init", 32'(init_n), 32'd1);
        // three-block message, blk_val held high
        clr_log();
        for (int i = 0; i < 300 && dgst_q.size() == 0; i++) step(1'b0, 1'b1, ack_q.size() == 2);
        step(1'b0, 1'b0, 1'b0);
        check("3b_acks", 32'(ack_q.size()), 32'd3);
        check("3b_ack1", 32'(ack_q.size() > 1 ? ack_q[1] : -1), 32'd68);
        check("3b_ack2", 32'(ack_q.size() > 2 ? ack_q[2] : -1), 32'd135);
        check("3b_dgst", 32'(dgst_q.size() > 0 ? dgst_q[0] : -1), 32'd202);
        check("3b_init", 32'(init_n), 32'd1);
        // back-to-back single-block messages
        clr_log();
        repeat (138) step(1'b0, 1'b1, 1'b1);
        repeat (3) step(1'b0, 1'b0, 1'b0);
        check("bb_acks", 32'(ack_q.size()), 32'd2);
        check("bb_ack1", 32'(ack_q.size() > 1 ? ack_q[1] : -1), 32'd69);
        check("bb_dgst1", 32'(dgst_q.size() > 1 ? dgst_q[1] : -1), 32'd137);
        check("bb_init", 32'(init_n), 32'd2);
        // mid-compression reset after a completed non-last block
        step(1'b0, 1'b1, 1'b0);
        repeat (70) step(1'b0, 1'b0, 1'b0);
        clr_log();
        step(1'b0, 1'b1, 1'b0);
        hit = 1'b0;
        for (int i = 0; i < 100 && !hit; i++) begin
            step(1'b0, 1'b0, 1'b0);
            hit = bus.rnd == 6'd30;
        end
        check("mr_reach30", 32'(hit), 32'd1);
        check("mr_noinit", 32'(init_n), 32'd0);
        step(1'b1, 1'b0, 1'b0);
        repeat (70) step(1'b0, 1'b0, 1'b0);
        check("mr_noupd", 32'(upd_n), 32'd0);
        check("mr_nodgst", 32'(dgst_q.size()), 32'd0);
        step(1'b0, 1'b1, 1'b1);
        repeat (75) step(1'b0, 1'b0, 1'b0);
        check("mr_reinit", 32'(init_n), 32'd1);
        // handshake: msg_end toggling during the round loop with blk_val held
        clr_log();
        step(1'b0, 1'b1, 1'b0);
        repeat (90) step(1'b0, 1'b1, ($urandom & 1) == 1);
        check("hs_ack1", 32'(ack_q.size() > 1 ? ack_q[1] : -1), 32'd68);
        check("hs_dgst", 32'(dgst_q.size()), 32'd0);
        // random traffic with occasional resets
        repeat (4000) step($urandom_range(0, 199) == 0, ($urandom & 3) != 0, $urandom_range(0, 2) == 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
